// File: rtl/ram_word_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ram_word_if : request/response bus between CPU bus FSM and RAM     |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
interface ram_word_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] address;
  logic                  width16;
  logic                  write_enable;
  logic [15:0]           data_in;
  logic [15:0]           data_out;
  logic                  busy;
  logic                  done;

  modport master (
    output start, address, width16, write_enable, data_in,
    input  data_out, busy, done
  );

  modport slave (
    input  start, address, width16, write_enable, data_in,
    output data_out, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/ram_word.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ram_word : even/odd byte-bank RAM, 8/16-bit little-endian accesses |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module ram_word #(
  parameter int    ADDR_WIDTH = 12,
  parameter string INIT_FILE  = ""
) (
  input  logic      clk,
  input  logic      reset,
  ram_word_if.slave bus
);

  localparam int c_row_w = ADDR_WIDTH - 1;
  localparam int c_depth = 2 ** c_row_w;
  localparam logic [c_row_w-1:0] c_row_one = 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PHASE2 = 2'd1,
    S_FINISH = 2'd2
  } state_e;

  logic [7:0] even_mem [c_depth];
  logic [7:0] odd_mem  [c_depth];

  state_e               state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [15:0]          data_out_q, data_out_d;
  logic                 lane_q, lane_d;
  logic                 wide_q, wide_d;
  logic                 wr_q, wr_d;
  logic [c_row_w-1:0]   row_q, row_d;
  logic [7:0]           hi_byte_q, hi_byte_d;
  logic [7:0]           lo_byte_q, lo_byte_d;

  logic                 ev_en, ev_we, od_en, od_we;
  logic [c_row_w-1:0]   ev_row, od_row;
  logic [7:0]           ev_wdata, od_wdata;
  logic [7:0]           even_rd_q, odd_rd_q;

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    data_out_d = data_out_q;
    lane_d     = lane_q;
    wide_d     = wide_q;
    wr_d       = wr_q;
    row_d      = row_q;
    hi_byte_d  = hi_byte_q;
    lo_byte_d  = lo_byte_q;
    ev_en      = 1'b0;
    ev_we      = 1'b0;
    ev_row     = bus.address[ADDR_WIDTH-1:1];
    ev_wdata   = bus.data_in[7:0];
    od_en      = 1'b0;
    od_we      = 1'b0;
    od_row     = bus.address[ADDR_WIDTH-1:1];
    od_wdata   = bus.data_in[7:0];

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          lane_d    = bus.address[0];
          wide_d    = bus.width16;
          wr_d      = bus.write_enable;
          hi_byte_d = bus.data_in[15:8];
          // Row of the high byte of an unaligned word; wraps at the top of the bank.
          row_d     = bus.address[ADDR_WIDTH-1:1] + c_row_one;
          busy_d    = 1'b1;
          if (bus.width16 && bus.address[0]) begin
            od_en   = 1'b1;
            od_we   = bus.write_enable;
            state_d = S_PHASE2;
          end else if (bus.width16) begin
            ev_en    = 1'b1;
            ev_we    = bus.write_enable;
            od_en    = 1'b1;
            od_we    = bus.write_enable;
            od_wdata = bus.data_in[15:8];
            state_d  = S_FINISH;
          end else begin
            ev_en   = !bus.address[0];
            ev_we   = bus.write_enable && !bus.address[0];
            od_en   = bus.address[0];
            od_we   = bus.write_enable && bus.address[0];
            state_d = S_FINISH;
          end
        end
      end
      S_PHASE2: begin
        lo_byte_d = odd_rd_q;
        ev_en     = 1'b1;
        ev_we     = wr_q;
        ev_row    = row_q;
        ev_wdata  = hi_byte_q;
        state_d   = S_FINISH;
      end
      S_FINISH: begin
        if (!wr_q) begin
          if (!wide_q)
            data_out_d = {8'h00, (lane_q ? odd_rd_q : even_rd_q)};
          else if (!lane_q)
            data_out_d = {odd_rd_q, even_rd_q};
          else
            data_out_d = {even_rd_q, lo_byte_q};
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      data_out_q <= 16'h0000;
      lane_q     <= 1'b0;
      wide_q     <= 1'b0;
      wr_q       <= 1'b0;
      row_q      <= '0;
      hi_byte_q  <= 8'h00;
      lo_byte_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      data_out_q <= data_out_d;
      lane_q     <= lane_d;
      wide_q     <= wide_d;
      wr_q       <= wr_d;
      row_q      <= row_d;
      hi_byte_q  <= hi_byte_d;
      lo_byte_q  <= lo_byte_d;
    end
  end

  // Storage is never reset; only the control path above is.
  always_ff @(posedge clk) begin
    if (ev_en) begin
      if (ev_we) even_mem[ev_row] <= ev_wdata;
      even_rd_q <= even_mem[ev_row];
    end
    if (od_en) begin
      if (od_we) odd_mem[od_row] <= od_wdata;
      odd_rd_q <= odd_mem[od_row];
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_word.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ram_word : scoreboard bench for ram_word                        |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_ram_word;

  localparam int AW = 12;

  typedef struct packed {
    logic [AW-1:0] a;
    logic          w16;
    logic          we;
    logic [15:0]   d;
  } acc_t;

  logic clk = 1'b0;
  logic reset;

  ram_word_if #(.ADDR_WIDTH(AW)) bus ();

  ram_word #(.ADDR_WIDTH(AW), .INIT_FILE("")) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  model [4096];
  logic [15:0] sb [$];
  logic [15:0] last_read = 16'h0000;

  // Expected completion value: read data from the model, or the held data_out for writes.
  task automatic push_expect(input acc_t x);
    logic [AW-1:0] a1;
    logic [15:0]   e;
    a1 = x.a + 12'd1;
    if (x.we) begin
      model[x.a] = x.d[7:0];
      if (x.w16) model[a1] = x.d[15:8];
      sb.push_back(last_read);
    end else begin
      e = x.w16 ? {model[a1], model[x.a]} : {8'h00, model[x.a]};
      sb.push_back(e);
      last_read = e;
    end
  endtask

  task automatic drive(input acc_t x, output logic [15:0] dout, output int lat,
                       output bit bad_busy, output bit tmo);
    logic [31:0] r;
    @(negedge clk);
    bus.start = 1'b1; bus.address = x.a; bus.width16 = x.w16;
    bus.write_enable = x.we; bus.data_in = x.d;
    @(posedge clk); #1;
    r = $urandom;
    bus.start = 1'b0; bus.address = r[11:0]; bus.width16 = r[12];
    bus.write_enable = r[13]; bus.data_in = r[31:16];
    lat = 1; bad_busy = 1'b0;
    while (!bus.done && lat < 10) begin
      if (!bus.busy) bad_busy = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    tmo = !bus.done;
    if (bus.busy) bad_busy = 1'b1;
    dout = bus.data_out;
  endtask

  task automatic exec(input acc_t x, output logic [15:0] got, output logic [15:0] exp,
                      output int lat, output bit bb, output bit tmo);
    push_expect(x);
    drive(x, got, lat, bb, tmo);
    exp = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0; bus.address = '0; bus.width16 = 1'b0;
    bus.write_enable = 1'b0; bus.data_in = 16'h0000;
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", bus.done); end
    n_cmp++; if (bus.data_out !== 16'h0000) begin n_bad++; $display("FAIL reset_data_out got %h want 0000", bus.data_out); end
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if ({bus.busy, bus.done} !== 2'b00) begin n_bad++; $display("FAIL reset_idle busy/done got %b want 00", {bus.busy, bus.done}); end
  endtask

  task automatic run_table(input string nm, input acc_t seq[], input int n);
    logic [15:0] got, exp;
    int lat, want;
    bit bb, tmo;
    for (int i = 0; i < n; i++) begin
      want = (seq[i].w16 && seq[i].a[0]) ? 3 : 2;
      exec(seq[i], got, exp, lat, bb, tmo);
      n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL %s[%0d] data_out got %h want %h", nm, i, got, exp); end
      n_cmp++; if (lat !== want) begin n_bad++; $display("FAIL %s[%0d] latency got %0d want %0d", nm, i, lat, want); end
      n_cmp++; if (bb || tmo) begin n_bad++; $display("FAIL %s[%0d] busy_bad=%0d timeout=%0d want 0 0", nm, i, bb, tmo); end
    end
  endtask

  task automatic test_byte();
    acc_t seq[] = '{'{12'h010, 1'b0, 1'b1, 16'hFFA5}, '{12'h010, 1'b0, 1'b0, 16'h0000},
                    '{12'h011, 1'b0, 1'b1, 16'h003C}, '{12'h011, 1'b0, 1'b0, 16'h0000}};
    run_table("byte", seq, 4);
  endtask

  task automatic test_aligned();
    acc_t seq[] = '{'{12'h020, 1'b1, 1'b1, 16'h1234}, '{12'h020, 1'b0, 1'b0, 16'h0000},
                    '{12'h021, 1'b0, 1'b0, 16'h0000}, '{12'h020, 1'b1, 1'b0, 16'h0000}};
    run_table("aligned", seq, 4);
  endtask

  task automatic test_unaligned();
    acc_t seq[] = '{'{12'h031, 1'b1, 1'b1, 16'hBEEF}, '{12'h031, 1'b0, 1'b0, 16'h0000},
                    '{12'h032, 1'b0, 1'b0, 16'h0000}, '{12'h031, 1'b1, 1'b0, 16'h0000}};
    run_table("unaligned", seq, 4);
  endtask

  task automatic test_wrap();
    acc_t seq[] = '{'{12'h000, 1'b0, 1'b1, 16'h0077}, '{12'hFFF, 1'b0, 1'b1, 16'h0066},
                    '{12'hFFF, 1'b1, 1'b0, 16'h0000}, '{12'hFFF, 1'b1, 1'b1, 16'h9988},
                    '{12'h000, 1'b0, 1'b0, 16'h0000}};
    run_table("wrap", seq, 5);
  endtask

  // Each single-phase access spans two edges, so only indices 0, 2 and 4 are accepted.
  task automatic test_back_to_back();
    acc_t b2b[6] = '{'{12'h010, 1'b0, 1'b0, 16'h0}, '{12'h031, 1'b1, 1'b0, 16'h0},
                     '{12'h020, 1'b1, 1'b0, 16'h0}, '{12'h010, 1'b0, 1'b1, 16'h00EE},
                     '{12'h021, 1'b0, 1'b0, 16'h0}, '{12'h011, 1'b0, 1'b1, 16'h00DD}};
    logic [15:0] exp;
    int ndone = 0;
    bit overlap = 1'b0;
    push_expect(b2b[0]); push_expect(b2b[2]); push_expect(b2b[4]);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i < 6) begin
        bus.start = 1'b1; bus.address = b2b[i].a; bus.width16 = b2b[i].w16;
        bus.write_enable = b2b[i].we; bus.data_in = b2b[i].d;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      if (bus.busy && bus.done) overlap = 1'b1;
      if (bus.done) begin
        ndone++;
        exp = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
        n_cmp++; if (bus.data_out !== exp) begin n_bad++; $display("FAIL b2b done%0d data_out got %h want %h", ndone, bus.data_out, exp); end
      end
    end
    n_cmp++; if (ndone !== 3) begin n_bad++; $display("FAIL b2b done_count got %0d want 3", ndone); end
    n_cmp++; if (overlap) begin n_bad++; $display("FAIL b2b busy_done_overlap got 1 want 0"); end
    sb.delete();
  endtask

  task automatic test_reset_abort();
    acc_t pre[] = '{'{12'h041, 1'b0, 1'b1, 16'h0011}, '{12'h042, 1'b0, 1'b1, 16'h005A}};
    acc_t post[] = '{'{12'h041, 1'b0, 1'b0, 16'h0}, '{12'h042, 1'b0, 1'b0, 16'h0}};
    bit saw_done = 1'b0;
    run_table("abort_pre", pre, 2);
    @(negedge clk);
    bus.start = 1'b1; bus.address = 12'h041; bus.width16 = 1'b1;
    bus.write_enable = 1'b1; bus.data_in = 16'hCAFE;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk) reset = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.done) saw_done = 1'b1;
    end
    @(negedge clk) reset = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      if (bus.done) saw_done = 1'b1;
    end
    n_cmp++; if (saw_done) begin n_bad++; $display("FAIL abort_done got 1 want 0"); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.data_out !== 16'h0000) begin n_bad++; $display("FAIL abort_data_out got %h want 0000", bus.data_out); end
    model[12'h041] = 8'hFE;
    last_read = 16'h0000;
    run_table("abort_post", post, 2);
  endtask

  initial begin
    test_reset();
    test_byte();
    test_aligned();
    test_unaligned();
    test_wrap();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
